// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencing controller (R/I-type ALU, LW, SW, BEQ) driving a
// single shared memory port with a req/ready handshake, trap logic and retire counter.
module multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             ab_we,
  output logic             mdr_we,
  output logic             rf_we,
  output logic             wb_sel,
  output logic             alusrc_imm,
  output logic [3:0]       alu_ctrl,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             trap_q, trap_d;
  logic [1:0]       cause_q, cause_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       in_access;
  logic       timeout_hit;
  logic       retire;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  assign in_access   = (state_q == S_FETCH) || (state_q == S_MEM);
  assign timeout_hit = in_access && !mem_ready && (to_cnt_q == TO_LAST);

  // State register and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      to_cnt_q  <= '0;
      retired_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      retired_q <= retired_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    trap_d  = trap_q;
    cause_d = cause_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (opcode == OP_R || opcode == OP_I || opcode == OP_LW ||
            opcode == OP_SW || opcode == OP_BEQ) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        if (opcode == OP_R || opcode == OP_I) begin
          state_d = S_WB;
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          state_d = S_MEM;
        end else if (opcode == OP_BEQ) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else begin
          // Only reachable if the IR changes after DECODE
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase
  end

  // Wait counter restarts on every state change, so each access gets a fresh budget
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_d != state_q) begin
      to_cnt_d = '0;
    end else if (in_access && !mem_ready) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic [6:0] f7,
                                            input logic is_r);
    logic [3:0] code;
    code = 4'b0000;
    case (f3)
      3'b000: code = (is_r && f7 == F7_ALT) ? 4'b0001 : 4'b0000;
      3'b001: code = is_r ? 4'b1010 : 4'b0000;
      3'b010: code = 4'b0101;
      3'b011: code = 4'b0110;
      3'b100: code = 4'b0111;
      3'b101: code = !is_r ? 4'b0000 : (f7 == F7_ALT) ? 4'b1001 : 4'b1000;
      3'b110: code = 4'b0011;
      3'b111: code = 4'b0010;
      default: code = 4'b0000;
    endcase
    return code;
  endfunction

  // Output decode; reset forces every strobe low in the same cycle
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_we      = 1'b0;
    ab_we      = 1'b0;
    mdr_we     = 1'b0;
    rf_we      = 1'b0;
    wb_sel     = 1'b0;
    alusrc_imm = 1'b0;
    alu_ctrl   = 4'b0000;
    pc_we      = 1'b0;
    pc_sel     = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
        end
        S_DECODE: ab_we = 1'b1;
        S_EXEC: begin
          alusrc_imm = (opcode == OP_I) || (opcode == OP_LW) || (opcode == OP_SW);
          if (opcode == OP_R) begin
            alu_ctrl = alu_decode(funct3, funct7, 1'b1);
          end else if (opcode == OP_I) begin
            alu_ctrl = alu_decode(funct3, funct7, 1'b0);
          end else if (opcode == OP_BEQ) begin
            alu_ctrl = 4'b0001;
            pc_we    = 1'b1;
            pc_sel   = zero;
          end
        end
        S_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (opcode == OP_SW);
          if (mem_ready) begin
            pc_we  = (opcode == OP_SW);
            mdr_we = (opcode != OP_SW);
          end
        end
        S_WB: begin
          rf_we  = 1'b1;
          wb_sel = (opcode == OP_LW);
          pc_we  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign trap       = trap_q & ~rst;
  assign trap_cause = rst ? 2'b00 : cause_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: expected control vectors are queued as each
// cycle's stimulus is driven and popped/compared at the following falling edge.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, addr_sel, ir_we, ab_we, mdr_we, rf_we, wb_sel;
  logic        alusrc_imm, pc_we, pc_sel, trap;
  logic [3:0]  alu_ctrl;
  logic [1:0]  trap_cause;
  logic [31:0] retired;

  int checks = 0;
  int passes = 0;
  logic [31:0] exp_ret = 0;
  logic [17:0] exp_q[$];

  multicycle_ctrl #(.CNT_W(32), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
    .ab_we(ab_we), .mdr_we(mdr_we), .rf_we(rf_we), .wb_sel(wb_sel),
    .alusrc_imm(alusrc_imm), .alu_ctrl(alu_ctrl), .pc_we(pc_we), .pc_sel(pc_sel),
    .trap(trap), .trap_cause(trap_cause), .retired(retired)
  );

  always #5 clk = ~clk;

  logic [17:0] obs;
  assign obs = {mem_req, mem_we, addr_sel, ir_we, ab_we, mdr_we, rf_we, wb_sel,
                alusrc_imm, alu_ctrl, pc_we, pc_sel, trap, trap_cause};

  function automatic logic [17:0] ov(input logic req, we, asel, ir, ab, mdr, rf, wbs, imm,
                                     input logic [3:0] alu, input logic pcwe, pcsel, tr,
                                     input logic [1:0] cause);
    return {req, we, asel, ir, ab, mdr, rf, wbs, imm, alu, pcwe, pcsel, tr, cause};
  endfunction

  function automatic logic [17:0] o_fetch(input logic rdy);
    return ov(1, 0, 0, rdy, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 2'b00);
  endfunction
  function automatic logic [17:0] o_dec();
    return ov(0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 2'b00);
  endfunction
  function automatic logic [17:0] o_exec(input logic imm, input logic [3:0] alu,
                                         input logic pcwe, pcsel);
    return ov(0, 0, 0, 0, 0, 0, 0, 0, imm, alu, pcwe, pcsel, 0, 2'b00);
  endfunction
  function automatic logic [17:0] o_mem(input logic we, mdr, pcwe);
    return ov(1, we, 1, 0, 0, mdr, 0, 0, 0, 4'b0000, pcwe, 0, 0, 2'b00);
  endfunction
  function automatic logic [17:0] o_wb(input logic wbs);
    return ov(0, 0, 0, 0, 0, 0, 1, wbs, 0, 4'b0000, 1, 0, 0, 2'b00);
  endfunction
  function automatic logic [17:0] o_trap(input logic [1:0] cause);
    return ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 1, cause);
  endfunction

  // One clock cycle: queue expectation, compare at falling edge, advance past rising edge
  task automatic cyc(input string tag, input logic [17:0] e);
    logic [17:0] want;
    exp_q.push_back(e);
    @(negedge clk);
    want = exp_q.pop_front();
    checks++;
    assert (obs === want) passes++;
    else $error("FAIL %s: observed %05h expected %05h", tag, obs, want);
    $display("cyc %-10s obs=%05h exp=%05h", tag, obs, want);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ret(input string tag);
    checks++;
    assert (retired === exp_ret) passes++;
    else $error("FAIL %s: retired observed %0d expected %0d", tag, retired, exp_ret);
    $display("ret %-10s obs=%0d exp=%0d", tag, retired, exp_ret);
  endtask

  task automatic run_alu(input string tag, input logic [31:0] ins, input logic imm,
                         input logic [3:0] alu);
    instr = ins;
    mem_ready = 1'b1;
    cyc({tag, "_f"}, o_fetch(1));
    cyc({tag, "_d"}, o_dec());
    cyc({tag, "_x"}, o_exec(imm, alu, 0, 0));
    cyc({tag, "_wb"}, o_wb(0));
    exp_ret++;
    chk_ret({tag, "_ret"});
  endtask

  task automatic sw_to_mem(input string tag);
    instr = 32'h0020A023;
    mem_ready = 1'b1;
    cyc({tag, "_f"}, o_fetch(1));
    cyc({tag, "_d"}, o_dec());
    cyc({tag, "_x"}, o_exec(1, 4'b0000, 0, 0));
  endtask

  initial begin
    rst = 1'b1; instr = 32'h0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    cyc("rst_outs", '0);
    chk_ret("rst_ret");
    rst = 1'b0;

    run_alu("add",  32'h002081B3, 0, 4'b0000);
    run_alu("sub",  32'h402081B3, 0, 4'b0001);
    run_alu("sra",  32'h4020D1B3, 0, 4'b1001);
    run_alu("sltu", 32'h0020B1B3, 0, 4'b0110);
    run_alu("slli", 32'h00109193, 1, 4'b0000);
    run_alu("xori", 32'h0FF0C193, 1, 4'b0111);

    // LW with a waited fetch and two wait cycles in MEM
    instr = 32'h00802283;
    mem_ready = 1'b0;
    cyc("lw_fw0", o_fetch(0));
    cyc("lw_fw1", o_fetch(0));
    mem_ready = 1'b1;
    cyc("lw_f", o_fetch(1));
    cyc("lw_d", o_dec());
    cyc("lw_x", o_exec(1, 4'b0000, 0, 0));
    mem_ready = 1'b0;
    cyc("lw_m0", o_mem(0, 0, 0));
    cyc("lw_m1", o_mem(0, 0, 0));
    mem_ready = 1'b1;
    cyc("lw_m2", o_mem(0, 1, 0));
    chk_ret("lw_ret_mid");
    cyc("lw_wb", o_wb(1));
    exp_ret++;
    chk_ret("lw_ret");

    // BEQ taken then not taken
    instr = 32'h00208463;
    zero = 1'b1;
    cyc("beq1_f", o_fetch(1));
    cyc("beq1_d", o_dec());
    cyc("beq1_x", o_exec(0, 4'b0001, 1, 1));
    exp_ret++;
    chk_ret("beq1_ret");
    zero = 1'b0;
    cyc("beq0_f", o_fetch(1));
    cyc("beq0_d", o_dec());
    cyc("beq0_x", o_exec(0, 4'b0001, 1, 0));
    exp_ret++;
    chk_ret("beq0_ret");

    // SW zero-wait
    sw_to_mem("sw");
    cyc("sw_m", o_mem(1, 0, 1));
    exp_ret++;
    chk_ret("sw_ret");

    // SW with ready on the last permitted cycle
    sw_to_mem("swl");
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) cyc("swl_wait", o_mem(1, 0, 0));
    mem_ready = 1'b1;
    cyc("swl_m16", o_mem(1, 0, 1));
    exp_ret++;
    chk_ret("swl_ret");
    mem_ready = 1'b0;
    cyc("swl_next", o_fetch(0));

    // SW timeout
    sw_to_mem("swt");
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) cyc("swt_wait", o_mem(1, 0, 0));
    cyc("swt_trap0", o_trap(2'b10));
    mem_ready = 1'b1;
    cyc("swt_trap1", o_trap(2'b10));
    chk_ret("swt_ret");
    rst = 1'b1;
    cyc("swt_rst", '0);
    exp_ret = 0;
    chk_ret("swt_rst_ret");
    rst = 1'b0;

    // Illegal opcode
    instr = 32'h0000007F;
    mem_ready = 1'b1;
    cyc("ill_f", o_fetch(1));
    cyc("ill_d", o_dec());
    for (int i = 0; i < 3; i++) cyc("ill_trap", o_trap(2'b01));
    rst = 1'b1;
    cyc("ill_rst", '0);
    rst = 1'b0;
    mem_ready = 1'b0;
    cyc("ill_fetch", o_fetch(0));
    chk_ret("ill_ret");

    // Reset in the middle of a waited SW access
    sw_to_mem("swr");
    mem_ready = 1'b0;
    cyc("swr_m0", o_mem(1, 0, 0));
    cyc("swr_m1", o_mem(1, 0, 0));
    rst = 1'b1;
    cyc("swr_rst", '0);
    rst = 1'b0;
    cyc("swr_fetch", o_fetch(0));
    chk_ret("swr_ret");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Sequencing controller for the multi-cycle variant of the RV32I core (subset: R-type ALU, I-type ALU, LW, SW, BEQ).
- Steps one instruction through FETCH/DECODE/EXEC/MEM/WB over a single shared instruction/data memory port, using a req/ready handshake.
- Generates the 4-bit ALU control code, register, PC and memory strobes, an illegal/bus-error trap and a retired-instruction counter.
- Sits between the instruction register, ALU/register-file datapath and the unified memory.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W).
- MEM_TIMEOUT, 16, max cycles mem_req may stay high without mem_ready before a bus-error trap (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- instr  in  32  instruction register contents (valid from DECODE onward).
- zero  in  1  ALU zero flag, sampled in EXEC.
- mem_ready  in  1  memory completes the access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = store access (valid only with mem_req).
- addr_sel  out  1  0 = PC drives the memory address, 1 = ALU result register drives it.
- ir_we  out  1  load the instruction register from memory read data.
- ab_we  out  1  latch register-file operands A/B.
- mdr_we  out  1  latch memory read data.
- rf_we  out  1  register-file write enable.
- wb_sel  out  1  write-back source: 0 = ALU result, 1 = MDR.
- alusrc_imm  out  1  ALU operand B: 0 = register B, 1 = immediate.
- alu_ctrl  out  4  ALU operation code.
- pc_we  out  1  PC update strobe.
- pc_sel  out  1  next PC: 0 = PC+4, 1 = branch target.
- trap  out  1  sticky fault indicator.
- trap_cause  out  2  00 none, 01 illegal instruction, 10 memory timeout.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Clocking and reset: one clock domain; all state updates on rising clk; reset synchronous, active-high.
- Reset values: while rst=1, state <= FETCH, retired <= 0, trap <= 0, trap_cause <= 00, timeout counter <= 0. All strobes (mem_req, mem_we, ir_we, ab_we, mdr_we, rf_we, pc_we) = 0, alu_ctrl = 0000, sel outputs = 0. Reset overrides everything, including mid-handshake: mem_req drops in the same cycle.
- Output decode: outputs are decoded combinationally from the state register plus instr[6:0], instr[14:12] and instr[31:25]. The state register is the only sequential control element besides the counters.
- FETCH: mem_req=1, addr_sel=0, mem_we=0; hold until mem_ready=1. In the mem_ready cycle ir_we=1, then go to DECODE.
- DECODE: ab_we=1. Opcode 0110011/0010011/0000011/0100011/1100011 -> EXEC; any other opcode -> TRAP with cause 01.
- EXEC:
  - alusrc_imm=1 for I-type, LW and SW.
  - ALU codes: LW/SW add 0000; BEQ sub 0001.
  - R-type by funct3: 000 add 0000 / sub 0001 (funct7=0100000), 001 sll 1010, 010 slt 0101, 011 sltu 0110, 100 xor 0111, 101 srl 1000 / sra 1001, 110 or 0011, 111 and 0010.
  - I-type: same mapping as R-type for 000/010/011/100/110/111; other funct3 -> 0000.
  - Next state: R/I -> WB; LW/SW -> MEM.
  - BEQ: pc_we=1, pc_sel=zero, retired+1, -> FETCH.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for SW; hold until mem_ready. On ready: SW -> pc_we=1, pc_sel=0, retired+1, -> FETCH; LW -> mdr_we=1, -> WB.
- WB: rf_we=1, wb_sel=1 for LW else 0, pc_we=1, pc_sel=0, retired+1, -> FETCH (single cycle).
- Handshake rules:
  - mem_req, addr_sel and mem_we stay stable until mem_ready is sampled high.
  - mem_ready while mem_req=0 is ignored.
  - mem_ready in the same cycle req first rises is a valid 1-cycle access.
- Timeout: counter clears on entry to FETCH/MEM and increments each cycle with mem_req=1 and mem_ready=0. On reaching MEM_TIMEOUT -> TRAP with cause 10. A mem_ready arriving on the same cycle the count hits the limit wins: access completes, no trap.
- TRAP: all strobes 0, trap=1, trap_cause held; exit only by rst.
- Latency: BEQ 3 cycles, R/I 4, SW 4, LW 5 (zero-wait memory).
- Counter: retired wraps from all-ones to 0 without a flag.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), mem_ready tied 1 -> FETCH,DECODE,EXEC(alu_ctrl=0000),WB(rf_we=1,wb_sel=0,pc_we=1); retired=1 after 4 cycles.
- LW x5,8(x0) (0x00802283) with mem_ready delayed 2 cycles in MEM -> mem_req/addr_sel=1 held stable 3 cycles, mdr_we one cycle, WB wb_sel=1; total 7 cycles.
- BEQ (0x00208463) with zero=1, then zero=0 -> EXEC alu_ctrl=0001, pc_we=1 with pc_sel=1 then 0; no rf_we; 3 cycles each.
- Opcode 0x0000007F -> DECODE to TRAP, trap=1, trap_cause=01, all strobes 0 indefinitely; rst=1 one cycle -> FETCH, retired=0.
- SW with mem_ready never asserted, MEM_TIMEOUT=16 -> trap_cause=10 after 16 cycles of mem_req; repeat with mem_ready on cycle 16 -> no trap, pc_we=1.
- rst asserted mid-MEM of SW -> next cycle mem_req=0, mem_we=0, state FETCH, retired unchanged at 0.
